instr_ram_loader: RTL and testbench

//  Bus initiator that fills the instruction RAM from a byte stream (debug/SPI/UART loader side).
//  - Packs incoming bytes little-endian into 32-bit words.
//  - Issues sequential single-cycle writes on the en/addr/we/be/wdata RAM port.
//  - Sits in front of the instruction RAM wrapper, muxed with the core fetch port while busy_o=1.

---
 rtl/instr_ram_loader_if.sv | 21 ++
 rtl/instr_ram_loader.sv | 211 +++++++++++++++++++++
 tb/tb_instr_ram_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_ram_loader_if.sv
// Instruction RAM write/read port between the loader (master) and the RAM wrapper (slave).
interface instr_ram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  ram_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic                  ram_we_o;
    logic [3:0]            ram_be_o;
    logic [31:0]           ram_rdata_i;

    modport master (
        output ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        input  ram_rdata_i
    );

    modport slave (
        input  ram_en_o, ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/instr_ram_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them sequentially to instruction RAM.
// Optional read-back verify after each write is enabled by defining LOADER_VERIFY_EN.
module instr_ram_loader #(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE) + 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_last_i,
    output logic                  byte_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] words_o,
    instr_ram_loader_if.master    ram
);
    localparam int unsigned LANES  = DATA_WIDTH / 8;
    localparam int unsigned LCNT_W = $clog2(LANES);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_COLLECT = 3'd1, S_WRITE = 3'd2, S_VRD = 3'd3, S_VCMP = 3'd4, S_DONE = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_COLLECT = 3'd1, S_WRITE = 3'd2, S_DONE = 3'd5
    } state_e;
`endif

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   words_q, words_d;
    logic [LCNT_W-1:0]       lcnt_q, lcnt_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [LANES-1:0]        be_q, be_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ram_en_q, ram_en_d;
    logic                    ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic [LANES-1:0]        ram_be_q, ram_be_d;
`ifdef LOADER_VERIFY_EN
    logic [DATA_WIDTH-1:0]   cmp_mask_c;
`else
    logic                    unused_rdata_c;
    assign unused_rdata_c = ^ram.ram_rdata_i;
`endif

    // Next-state and next-output logic; all outputs are registered from their _d values.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        words_d     = words_q;
        lcnt_d      = lcnt_q;
        word_d      = word_q;
        be_d        = be_q;
        last_d      = last_q;
        err_d       = err_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_be_d    = '0;
`ifdef LOADER_VERIFY_EN
        cmp_mask_c  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            cmp_mask_c[i*8 +: 8] = {8{be_q[i]}};
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    words_d = '0;
                    err_d   = 1'b0;
                    lcnt_d  = '0;
                    word_d  = '0;
                    be_d    = '0;
                    last_d  = 1'b0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_valid_i && ready_q) begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        if (lcnt_q == LCNT_W'(i)) begin
                            word_d[i*8 +: 8] = byte_i;
                            be_d[i]          = 1'b1;
                        end
                    end
                    lcnt_d = lcnt_q + LCNT_W'(1);
                    last_d = byte_last_i;
                    if (lcnt_q == LCNT_W'(LANES - 1) || byte_last_i) begin
                        // Addresses at or above RAM_SIZE belong to the boot ROM and are never written.
                        if (addr_q >= ADDR_WIDTH'(RAM_SIZE)) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            ram_en_d    = 1'b1;
                            ram_we_d    = 1'b1;
                            ram_addr_d  = addr_q;
                            ram_wdata_d = word_d;
                            ram_be_d    = be_d;
                            state_d     = S_WRITE;
                        end
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(4);
                words_d = words_q + ADDR_WIDTH'(1);
`ifdef LOADER_VERIFY_EN
                ram_en_d   = 1'b1;
                ram_addr_d = addr_q;
                ram_be_d   = '1;
                state_d    = S_VRD;
`else
                lcnt_d  = '0;
                word_d  = '0;
                be_d    = '0;
                state_d = last_q ? S_DONE : S_COLLECT;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VRD: begin
                state_d = S_VCMP;
            end
            S_VCMP: begin
                lcnt_d = '0;
                word_d = '0;
                be_d   = '0;
                if (|((ram.ram_rdata_i ^ word_q) & cmp_mask_c)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = last_q ? S_DONE : S_COLLECT;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_COLLECT);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            lcnt_q      <= '0;
            word_q      <= '0;
            be_q        <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            lcnt_q      <= lcnt_d;
            word_q      <= word_d;
            be_q        <= be_d;
            last_q      <= last_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
        end
    end

    assign byte_ready_o    = ready_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign words_o         = words_q;
    assign ram.ram_en_o    = ram_en_q;
    assign ram.ram_we_o    = ram_we_q;
    assign ram.ram_addr_o  = ram_addr_q;
    assign ram.ram_wdata_o = ram_wdata_q;
    assign ram.ram_be_o    = ram_be_q;
endmodule

// File: tb/tb_instr_ram_loader.sv
// Directed, table-driven bench for instr_ram_loader with a simple RAM model and write monitor.
module tb_instr_ram_loader;
    localparam int unsigned RAM_SIZE = 32768;
    localparam int unsigned AW       = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          byte_valid;
    logic [7:0]    byte_d;
    logic          byte_last;
    logic          byte_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] words;

    instr_ram_loader_if #(.ADDR_WIDTH(AW)) ram_if ();

    instr_ram_loader #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .byte_valid_i (byte_valid),
        .byte_i       (byte_d),
        .byte_last_i  (byte_last),
        .byte_ready_o (byte_ready),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .words_o      (words),
        .ram          (ram_if)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: byte-enabled writes, registered read data.
    logic [31:0] mem [bit [AW-1:0]];
    always @(posedge clk) begin
        if (ram_if.ram_en_o) begin
            if (ram_if.ram_we_o) begin
                logic [31:0] w;
                w = mem.exists(ram_if.ram_addr_o) ? mem[ram_if.ram_addr_o] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (ram_if.ram_be_o[i]) w[i*8 +: 8] = ram_if.ram_wdata_o[i*8 +: 8];
                mem[ram_if.ram_addr_o] = w;
            end else begin
                ram_if.ram_rdata_i <= mem.exists(ram_if.ram_addr_o) ? mem[ram_if.ram_addr_o] : 32'h0;
            end
        end
    end

    // Write monitor, sampled on the falling edge.
    logic [AW-1:0] wr_addr [$];
    logic [31:0]   wr_data [$];
    logic [3:0]    wr_be   [$];
    int            done_cnt = 0;
    int            rom_writes = 0;
    always @(negedge clk) begin
        if (ram_if.ram_en_o && ram_if.ram_we_o) begin
            wr_addr.push_back(ram_if.ram_addr_o);
            wr_data.push_back(ram_if.ram_wdata_o);
            wr_be.push_back(ram_if.ram_be_o);
            if (ram_if.ram_addr_o >= AW'(RAM_SIZE)) rom_writes++;
        end
        if (done) done_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            n;
        int            gap;
        int            nwr;
        logic [AW-1:0] a0;
        logic [31:0]   d0;
        logic [3:0]    be0;
        logic [AW-1:0] a1;
        logic [31:0]   d1;
        logic [3:0]    be1;
        logic [AW-1:0] words;
        logic          err;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [7:0] pat(input int i);
        return 8'((i + 1) * 17);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
        int cyc;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_d     = b;
        byte_last  = l;
        cyc        = 0;
        while (!byte_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) check("byte_accept_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_be.delete();
        done_cnt = 0;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        clear_mon();
        pulse_start(v.base);
        for (int i = 0; i < v.n; i++) send_byte(pat(i), i == v.n - 1, v.gap);
        wait_done();
        check($sformatf("v%0d_words", k), 64'(words), 64'(v.words));
        check($sformatf("v%0d_err", k), 64'(err), 64'(v.err));
        check($sformatf("v%0d_busy_at_done", k), 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_nwrites", k), 64'(wr_addr.size()), 64'(v.nwr));
        check($sformatf("v%0d_done_pulses", k), 64'(done_cnt), 64'd1);
        check($sformatf("v%0d_first", k), {wr_addr[0], wr_data[0], 12'(wr_be[0])},
              {v.a0, v.d0, 12'(v.be0)});
        check($sformatf("v%0d_last", k), {wr_addr[$], wr_data[$], 12'(wr_be[$])},
              {v.a1, v.d1, 12'(v.be1)});
    endtask

    initial begin
        //          base      n  gap nwr a0        d0            be0     a1        d1            be1     words err
        vecs[0] = '{16'h0100, 5, 0, 2, 16'h0100, 32'h44332211, 4'hF, 16'h0104, 32'h00000055, 4'h1, 16'd2, 1'b0};
        vecs[1] = '{16'h0200, 8, 2, 2, 16'h0200, 32'h44332211, 4'hF, 16'h0204, 32'h88776655, 4'hF, 16'd2, 1'b0};
        vecs[2] = '{16'h7FFC, 8, 0, 1, 16'h7FFC, 32'h44332211, 4'hF, 16'h7FFC, 32'h44332211, 4'hF, 16'd1, 1'b1};
        vecs[3] = '{16'h0103, 3, 0, 1, 16'h0100, 32'h00332211, 4'h7, 16'h0100, 32'h00332211, 4'h7, 16'd1, 1'b0};
        vecs[4] = '{16'h0000, 1, 1, 1, 16'h0000, 32'h00000011, 4'h1, 16'h0000, 32'h00000011, 4'h1, 16'd1, 1'b0};
        vecs[5] = '{16'h7FF8, 6, 0, 2, 16'h7FF8, 32'h44332211, 4'hF, 16'h7FFC, 32'h00006655, 4'h3, 16'd2, 1'b0};

        rst = 1'b1; start = 1'b0; base_addr = '0;
        byte_valid = 1'b0; byte_d = '0; byte_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_words", 64'(words), 64'd0);
        check("rst_ram_en", 64'(ram_if.ram_en_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(byte_ready), 64'd0);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Reset mid-load: one full word written, two more bytes pending.
        clear_mon();
        pulse_start(16'h0300);
        for (int i = 0; i < 6; i++) send_byte(pat(i), 1'b0, 0);
        check("mid_rst_words_before", 64'(words), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs",
              {32'(ram_if.ram_wdata_o), 16'(ram_if.ram_addr_o), 4'(ram_if.ram_be_o), 6'd0,
               ram_if.ram_en_o, ram_if.ram_we_o, byte_ready, busy, done, err},
              64'd0);
        check("mid_rst_words", 64'(words), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_nwrites", 64'(wr_addr.size()), 64'd1);
        check("mid_rst_idle_busy", 64'(busy), 64'd0);
        run_vec(0);

        // Start pulse while busy is ignored; misaligned base is word-aligned.
        clear_mon();
        pulse_start(16'h0103);
        send_byte(pat(0), 1'b0, 0);
        pulse_start(16'h0500);
        check("restart_busy", 64'(busy), 64'd1);
        for (int i = 1; i < 4; i++) send_byte(pat(i), i == 3, 0);
        wait_done();
        check("restart_words", 64'(words), 64'd1);
        repeat (2) @(negedge clk);
        check("restart_nwrites", 64'(wr_addr.size()), 64'd1);
        check("restart_write", {wr_addr[0], wr_data[0], 12'(wr_be[0])},
              {16'h0100, 32'h44332211, 12'hF});

        // After done, stream bytes are not accepted in IDLE.
        byte_valid = 1'b1;
        byte_d     = 8'hAA;
        repeat (3) @(negedge clk);
        check("idle_no_accept", 64'(byte_ready), 64'd0);
        byte_valid = 1'b0;

        check("rom_never_written", 64'(rom_writes), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
